// File: rtl/clk_div_ctrl.sv
// Clock-enable sequencer: derives phase-aligned 4f/2f/1f strobes from clk32f
// with IDLE -> WARMUP -> RUN sequencing. Optional en_8f output: CLK_DIV_CTRL_8F_EN.
module clk_div_ctrl #(
    parameter int WARMUP_CYC = 16,
    parameter int WCNT_W     = 8
) (
    input  logic       clk32f,
    input  logic       reset_L,
    input  logic       start,
    input  logic       stop,
    output logic       en_4f,
    output logic       en_2f,
    output logic       en_1f,
`ifdef CLK_DIV_CTRL_8F_EN
    output logic       en_8f,
`endif
    output logic       ready,
    output logic       busy,
    output logic [4:0] phase
);

    typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

    // Terminal warm-up count; unreachable when WARMUP_CYC is 0 since WARMUP is skipped.
    localparam logic [WCNT_W-1:0] WTERM =
        (WARMUP_CYC == 0) ? '0 : WCNT_W'(WARMUP_CYC - 1);

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              pend_q, pend_d;

    always_ff @(posedge clk32f or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        pend_d  = pend_q;
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                wcnt_d = '0;
                pend_d = 1'b0;
                if (start && !stop)
                    state_d = (WARMUP_CYC == 0) ? RUN : WARMUP;
            end
            WARMUP: begin
                if (stop) begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                end else if (wcnt_q == WTERM) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            RUN: begin
                pend_d = pend_q | stop;
                cnt_d  = cnt_q + 5'd1;
                // Stop only takes effect at the end of a full 1f period.
                if (cnt_q == 5'd31 && (pend_q || stop)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                wcnt_d  = '0;
                pend_d  = 1'b0;
            end
        endcase
    end

    logic run;
    assign run   = (state_q == RUN);
    assign ready = run;
    assign busy  = (state_q != IDLE);
    assign phase = cnt_q;
    assign en_4f = run && (cnt_q[2:0] == 3'b111);
    assign en_2f = run && (cnt_q[3:0] == 4'b1111);
    assign en_1f = run && (cnt_q == 5'd31);
`ifdef CLK_DIV_CTRL_8F_EN
    assign en_8f = run && (cnt_q[1:0] == 2'b11);
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed vector table, hand sequences and random
// stimulus checked cycle by cycle against a period-counting reference model.
module tb_clk_div_ctrl;

    localparam int W = 16;

    logic clk32f = 1'b0;
    logic reset_L, start, stop;
    logic en_4f, en_2f, en_1f, ready, busy;
    logic [4:0] phase;
    logic sb, pb;
    logic en_4f_b, en_2f_b, en_1f_b, ready_b, busy_b;
    logic [4:0] phase_b;
`ifdef CLK_DIV_CTRL_8F_EN
    logic en_8f, en_8f_b;
`endif

    always #5 clk32f = ~clk32f;

    clk_div_ctrl #(.WARMUP_CYC(W), .WCNT_W(8)) dut (
        .clk32f(clk32f), .reset_L(reset_L), .start(start), .stop(stop),
        .en_4f(en_4f), .en_2f(en_2f), .en_1f(en_1f),
`ifdef CLK_DIV_CTRL_8F_EN
        .en_8f(en_8f),
`endif
        .ready(ready), .busy(busy), .phase(phase)
    );

    clk_div_ctrl #(.WARMUP_CYC(0), .WCNT_W(8)) dut_b (
        .clk32f(clk32f), .reset_L(reset_L), .start(sb), .stop(pb),
        .en_4f(en_4f_b), .en_2f(en_2f_b), .en_1f(en_1f_b),
`ifdef CLK_DIV_CTRL_8F_EN
        .en_8f(en_8f_b),
`endif
        .ready(ready_b), .busy(busy_b), .phase(phase_b)
    );

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: mode 0 idle, 1 warm-up, 2 running; age counts cycles since RUN entry.
    int  m_mode, m_w, m_age;
    bit  m_req;

    function automatic void m_reset();
        m_mode = 0; m_w = 0; m_age = 0; m_req = 0;
    endfunction

    function automatic void m_step(input bit s, input bit p);
        case (m_mode)
            0: if (s && !p) begin
                if (W == 0) begin m_mode = 2; m_age = 0; end
                else begin m_mode = 1; m_w = 0; end
            end
            1: if (p) m_mode = 0;
               else if (m_w == W - 1) begin m_mode = 2; m_age = 0; end
               else m_w++;
            default: begin
                if (p) m_req = 1;
                if (m_age % 32 == 31 && m_req) begin
                    m_mode = 0; m_req = 0; m_age = 0;
                end else m_age++;
            end
        endcase
    endfunction

    function automatic logic [15:0] m_out();
        bit run;
        int ph;
        logic [15:0] o;
        run = (m_mode == 2);
        ph  = run ? m_age % 32 : 0;
        o = '0;
        o[4:0] = 5'(ph);
        o[5] = run;
        o[6] = (m_mode != 0);
        o[7] = run && (ph % 8 == 7);
        o[8] = run && (ph % 16 == 15);
        o[9] = run && (ph == 31);
        o[10] = run && (ph % 4 == 3);
        return o;
    endfunction

    function automatic logic [15:0] dut_out();
        logic [15:0] o;
        o = '0;
        o[4:0] = phase;
        o[5] = ready; o[6] = busy;
        o[7] = en_4f; o[8] = en_2f; o[9] = en_1f;
`ifdef CLK_DIV_CTRL_8F_EN
        o[10] = en_8f;
`else
        o[10] = (m_mode == 2) && (m_age % 32 % 4 == 3);
`endif
        return o;
    endfunction

    int c4, c2, c1, c8;

    task automatic cyc(input logic s, input logic p);
        logic [15:0] o;
        start = s; stop = p;
        @(posedge clk32f);
        m_step(s, p);
        #1;
        o = dut_out();
        chk("model", o, m_out());
        c4 += int'(o[7]); c2 += int'(o[8]); c1 += int'(o[9]); c8 += int'(o[10]);
    endtask

    task automatic async_reset();
        #2 reset_L = 1'b0;
        m_reset();
        #1 chk("async_reset", dut_out(), 16'h0);
        reset_L = 1'b1;
    endtask

    typedef struct {
        logic s, p;
        int   n;
        logic r, b;
        logic [4:0] ph;
        logic e4, e2, e1;
    } vec_t;

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{0,0, 2, 0,0, 5'd0, 0,0,0};
        tbl[1]  = '{1,0, 1, 0,1, 5'd0, 0,0,0};
        tbl[2]  = '{0,0,15, 0,1, 5'd0, 0,0,0};
        tbl[3]  = '{0,0, 1, 1,1, 5'd0, 0,0,0};
        tbl[4]  = '{0,0, 7, 1,1, 5'd7, 1,0,0};
        tbl[5]  = '{0,0, 8, 1,1, 5'd15,1,1,0};
        tbl[6]  = '{0,0,16, 1,1, 5'd31,1,1,1};
        tbl[7]  = '{0,0, 1, 1,1, 5'd0, 0,0,0};
        tbl[8]  = '{0,0, 5, 1,1, 5'd5, 0,0,0};
        tbl[9]  = '{0,1, 1, 1,1, 5'd6, 0,0,0};
        tbl[10] = '{0,0,25, 1,1, 5'd31,1,1,1};
        tbl[11] = '{0,0, 1, 0,0, 5'd0, 0,0,0};
        tbl[12] = '{1,1, 3, 0,0, 5'd0, 0,0,0};
        tbl[13] = '{1,0, 1, 0,1, 5'd0, 0,0,0};
        tbl[14] = '{0,0, 4, 0,1, 5'd0, 0,0,0};
        tbl[15] = '{0,1, 1, 0,0, 5'd0, 0,0,0};

        reset_L = 1'b0; start = 1'b0; stop = 1'b0; sb = 1'b0; pb = 1'b0;
        m_reset();
        #2 chk("reset_state", dut_out(), 16'h0);
        @(posedge clk32f); #1 reset_L = 1'b1;

        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < tbl[i].n; k++) cyc(tbl[i].s, tbl[i].p);
            chk($sformatf("vec%0d", i),
                {ready, busy, phase, en_4f, en_2f, en_1f},
                {tbl[i].r, tbl[i].b, tbl[i].ph, tbl[i].e4, tbl[i].e2, tbl[i].e1});
        end

        // Steady run: 128 cycles from RUN entry.
        cyc(1, 0);
        for (int k = 0; k < W; k++) cyc(0, 0);
        chk("run_entry", {ready, phase}, {1'b1, 5'd0});
        c4 = 0; c2 = 0; c1 = 0; c8 = 0;
        cyc(0, 0);
        for (int k = 0; k < 127; k++) cyc(0, 0);
        // The first counted cycle sits at phase 1, so phase 0 of the window closes it.
        chk("cnt_4f", c4, 16);
        chk("cnt_2f", c2, 8);
        chk("cnt_1f", c1, 4);
`ifdef CLK_DIV_CTRL_8F_EN
        chk("cnt_8f", c8, 32);
`endif

        // Async reset at phase 20, then restart through WARMUP.
        while (phase != 5'd20) cyc(0, 0);
        async_reset();
        cyc(1, 0);
        chk("restart_warm", {busy, ready}, 2'b10);
        for (int k = 0; k < W; k++) cyc(0, 0);
        chk("restart_run", ready, 1'b1);

        // Randomized traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 599) == 0) async_reset();
            cyc(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 19) == 0));
        end
        start = 1'b0; stop = 1'b0;

        // Zero warm-up instance.
        sb = 1'b1; pb = 1'b1;
        @(posedge clk32f); #1;
        chk("b_both_idle", {busy_b, ready_b}, 2'b00);
        pb = 1'b0;
        @(posedge clk32f); #1;
        chk("b_direct_run", {busy_b, ready_b, phase_b}, {2'b11, 5'd0});
        sb = 1'b0;
        repeat (31) @(posedge clk32f);
        #1 chk("b_strobes31", {en_4f_b, en_2f_b, en_1f_b, phase_b}, {3'b111, 5'd31});
        pb = 1'b1;
        @(posedge clk32f); #1;
        pb = 1'b0;
        chk("b_stop", {busy_b, ready_b, phase_b}, 7'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Single-clock sequencer for the divided-clock datapath: generates phase-aligned clock-enable strobes for the 4f, 2f and 1f rates from the 32f master clock.
- Owns the startup and shutdown sequence: reset, warm-up, run, and a graceful stop on a 1f boundary.
- Downstream serializer, mux and demux stages use its strobes as enables instead of ripple-divided clocks.

Parameters:
- WARMUP_CYC, 16, number of clk32f cycles spent in WARMUP before RUN; legal range 0..255.
- WCNT_W, 8, width of the warm-up counter; must satisfy 2^WCNT_W > WARMUP_CYC.

Ports:
- clk32f  input  1  master clock; all state changes on the rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- start  input  1  level request to begin the sequence; sampled in IDLE only.
- stop  input  1  request to halt; sampled in WARMUP and RUN.
- en_4f  output  1  one-cycle strobe every 8 clk32f cycles.
- en_2f  output  1  one-cycle strobe every 16 clk32f cycles.
- en_1f  output  1  one-cycle strobe every 32 clk32f cycles.
- ready  output  1  high while the FSM is in RUN.
- busy  output  1  high while in WARMUP or RUN.
- phase  output  5  current value of the run counter cnt.

Behaviour:
- Reset (reset_L=0, asynchronous, effective at any time):
  - state=IDLE, cnt=0, wcnt=0, stop_pend=0.
  - All outputs are 0.
  - Reset asserted mid-RUN kills strobes immediately; no final pulse is produced.
- States: IDLE, WARMUP, RUN. The FSM is encoded in registers; all outputs are Moore decodes of registered state and cnt (no input-to-output combinational paths).
- IDLE:
  - cnt=0, wcnt=0.
  - If start=1 and stop=0: go to WARMUP, or directly to RUN when WARMUP_CYC=0.
  - start and stop both high: stop wins, remain in IDLE.
- WARMUP:
  - wcnt increments each cycle.
  - When wcnt==WARMUP_CYC-1: go to RUN with cnt=0 and wcnt cleared.
  - stop=1: go to IDLE next cycle, wcnt cleared. stop has priority over the warm-up terminal count.
- RUN:
  - cnt increments by 1 each cycle, modulo 32 (31 wraps to 0).
  - en_4f=1 when cnt[2:0]==7 (cnt = 7, 15, 23, 31).
  - en_2f=1 when cnt[3:0]==15 (cnt = 15, 31).
  - en_1f=1 when cnt==31.
  - All strobes coincide at cnt=31. The first en_4f appears exactly 8 cycles after RUN entry (cnt=0..7).
- Stop in RUN:
  - stop=1 sets stop_pend, which stays set even if stop deasserts.
  - When cnt==31 and (stop_pend or stop): the en_1f strobe of that cycle is still issued, then the FSM goes to IDLE, cnt=0, stop_pend=0.
  - The stream therefore always ends on a complete 1f period; no truncated period.
- start while in WARMUP or RUN is ignored.
- A held start after returning to IDLE restarts the sequence on the next cycle unless stop is high.
- ready=(state==RUN). busy=(state!=IDLE). phase=cnt, which is 0 outside RUN.

Optional Feature:
- Macro: CLK_DIV_CTRL_8F_EN.
- Defined:
  - Adds output port en_8f (1 bit).
  - en_8f=1 in RUN when cnt[1:0]==3, i.e. every 4 cycles, aligned so it coincides with en_4f at cnt=7.
  - en_8f resets to 0 and is 0 outside RUN.
- Undefined: the port and its logic do not exist; all other behaviour is identical.

Test Plan:
- Reset release, start pulse at cycle 2, WARMUP_CYC=16 -> busy=1 from cycle 3; ready=1 after 16 WARMUP cycles; first en_4f 8 cycles later, first en_1f 32 cycles after RUN entry.
- Steady RUN for 128 cycles -> exactly 16 en_4f, 8 en_2f and 4 en_1f pulses; every en_1f coincides with en_2f and en_4f; phase counts 0..31 repeatedly.
- stop pulsed 1 cycle at phase=5 -> strobes continue through phase=31 (en_1f issued); next cycle ready=0, busy=0, phase=0.
- stop during WARMUP (wcnt=4) -> IDLE next cycle, with no strobe ever issued.
- reset_L dropped asynchronously at phase=20 -> all outputs 0 immediately, without waiting for a clock edge; after release and a new start, the sequence restarts from WARMUP.
- WARMUP_CYC=0, start and stop both high in IDLE -> remains in IDLE; start alone -> ready=1 on the next cycle. With CLK_DIV_CTRL_8F_EN defined -> 32 en_8f pulses per 128 RUN cycles.
